// File: rtl/psr_branch_unit_if.sv
// Flag-write and branch-resolution bus between the ALU/decode side and the fetch stage.
interface psr_branch_unit_if;
  logic [15:0] flags_in;
  logic        arith_we;
  logic        cmp_we;
  logic        psr_wr_en;
  logic [15:0] psr_wr_data;
  logic        br_req;
  logic [3:0]  cond;
  logic [15:0] br_target;
  logic        br_ack;
  logic [15:0] psr_out;
  logic        br_valid;
  logic        br_taken;
  logic [15:0] br_addr;
  logic        busy;

  modport master (
    output flags_in, arith_we, cmp_we, psr_wr_en, psr_wr_data,
           br_req, cond, br_target, br_ack,
    input  psr_out, br_valid, br_taken, br_addr, busy
  );

  modport slave (
    input  flags_in, arith_we, cmp_we, psr_wr_en, psr_wr_data,
           br_req, cond, br_target, br_ack,
    output psr_out, br_valid, br_taken, br_addr, busy
  );
endinterface

// File: rtl/psr_branch_unit.sv
// Processor status register plus conditional-branch resolver with a registered
// taken/target decision handed to fetch over valid/ack.
module psr_branch_unit (
  input  logic               i_clk,
  input  logic               i_reset,
  psr_branch_unit_if.slave   bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  state_t      r_state, w_nxt;
  logic        r_n, r_z, r_f, r_l, r_c;
  logic [3:0]  r_cond;
  logic [15:0] r_addr;
  logic        r_taken;
  logic        w_cap, w_ld_taken, w_any_we, w_eval;
  logic [3:0]  w_cond_sel;
  logic        w_unused;

  assign w_unused = ^{bus.flags_in[15:8], bus.flags_in[4:3], bus.flags_in[1],
                      bus.psr_wr_data[15:8], bus.psr_wr_data[4:3], bus.psr_wr_data[1]};

  function automatic logic f_eval(input logic [3:0] c, input logic n, z, f, l, cy);
    case (c)
      4'h0: f_eval = z;
      4'h1: f_eval = !z;
      4'h2: f_eval = cy;
      4'h3: f_eval = !cy;
      4'h4: f_eval = l;
      4'h5: f_eval = !l;
      4'h6: f_eval = n;
      4'h7: f_eval = !n;
      4'h8: f_eval = f;
      4'h9: f_eval = !f;
      4'hA: f_eval = !l && !z;
      4'hB: f_eval = l || z;
      4'hC: f_eval = !n && !z;
      4'hD: f_eval = n || z;
      4'hE: f_eval = 1'b1;
      default: f_eval = 1'b0;
    endcase
  endfunction

  // Software write wins outright; the two ALU enables touch disjoint flag groups.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      {r_n, r_z, r_f, r_l, r_c} <= '0;
    end else if (bus.psr_wr_en) begin
      r_n <= bus.psr_wr_data[7];
      r_z <= bus.psr_wr_data[6];
      r_f <= bus.psr_wr_data[5];
      r_l <= bus.psr_wr_data[2];
      r_c <= bus.psr_wr_data[0];
    end else begin
      if (bus.arith_we) begin
        r_f <= bus.flags_in[5];
        r_c <= bus.flags_in[0];
      end
      if (bus.cmp_we) begin
        r_n <= bus.flags_in[7];
        r_z <= bus.flags_in[6];
        r_l <= bus.flags_in[2];
      end
    end
  end

  assign w_any_we = bus.arith_we | bus.cmp_we | bus.psr_wr_en;

  always_comb begin
    w_nxt      = r_state;
    w_cap      = 1'b0;
    w_ld_taken = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.br_req) begin
          w_cap = 1'b1;
          // A same-cycle flag write would be missed; defer evaluation one cycle.
          if (w_any_we) begin
            w_nxt = ST_WAIT;
          end else begin
            w_nxt      = ST_HOLD;
            w_ld_taken = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        w_ld_taken = 1'b1;
        w_nxt      = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.br_ack) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign w_cond_sel = (r_state == ST_IDLE) ? bus.cond : r_cond;
  assign w_eval     = f_eval(w_cond_sel, r_n, r_z, r_f, r_l, r_c);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_cond  <= '0;
      r_addr  <= '0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_cap) begin
        r_cond <= bus.cond;
        r_addr <= bus.br_target;
      end
      if (w_ld_taken) r_taken <= w_eval;
    end
  end

  assign bus.psr_out  = {8'b0, r_n, r_z, r_f, 2'b00, r_l, 1'b0, r_c};
  assign bus.br_valid = (r_state == ST_HOLD);
  assign bus.br_taken = r_taken;
  assign bus.br_addr  = r_addr;
  assign bus.busy     = (r_state != ST_IDLE);
endmodule
